// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with a single-cycle multiplier and a WIDTH-step restoring divider.
// state     | meaning
// S_IDLE    | accepting ops; MULT/MTHI/MTLO commit immediately
// S_DIV_RUN | one restoring quotient bit per edge, cnt counts down to 1
// S_DIV_FIX | apply signs to quotient/remainder and commit to LO/HI
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DIV_RUN = 2'd1;
  localparam logic [1:0] S_DIV_FIX = 2'd2;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvsr;
  logic             neg_q;
  logic             neg_r;

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               is_signed_div;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;
  logic               take;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign is_signed_div = (op == OP_DIV);
  assign a_mag = (is_signed_div && a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_signed_div && b[WIDTH-1]) ? -b : b;

  // quo doubles as the dividend shift register; its MSB feeds the remainder each step
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvsr};
  assign take   = ~trial[WIDTH];

  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -rem : rem;

  assign busy = (state != S_IDLE);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      quo      <= '0;
      rem      <= '0;
      dvsr     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi_o     <= '0;
      lo_o     <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              case (op)
                OP_MULT: begin
                  {hi_o, lo_o} <= prod_s;
                  done         <= 1'b1;
                end
                OP_MULTU: begin
                  {hi_o, lo_o} <= prod_u;
                  done         <= 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                  if (b == '0) begin
                    done     <= 1'b1;
                    div_zero <= 1'b1;
                  end else begin
                    quo   <= a_mag;
                    rem   <= '0;
                    dvsr  <= b_mag;
                    neg_q <= is_signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_r <= is_signed_div & a[WIDTH-1];
                    cnt   <= CNT_INIT;
                    state <= S_DIV_RUN;
                  end
                end
                OP_MTHI: hi_o <= a;
                OP_MTLO: lo_o <= a;
                default: ;
              endcase
            end
          end
          S_DIV_RUN: begin
            rem <= take ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], take};
            cnt <= cnt - CNT_LAST;
            if (cnt == CNT_LAST) state <= S_DIV_FIX;
          end
          S_DIV_FIX: begin
            lo_o  <= q_fix;
            hi_o  <= r_fix;
            done  <= 1'b1;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Randomised scoreboard bench for hilo_muldiv_unit against a plain-arithmetic HI/LO model.
module tb_hilo_muldiv_unit;

  localparam int W = 32;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  logic         clk = 1'b1;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flush;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  hilo_muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .div_zero(div_zero), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] model_hi;
  logic [W-1:0] model_lo;
  int           n_chk = 0;
  int           n_fail = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void ref_mul(input bit s, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] h, output logic [W-1:0] l);
    logic [2*W-1:0] p;
    if (s) p = 64'(longint'($signed(x)) * longint'($signed(y)));
    else   p = {32'b0, x} * {32'b0, y};
    h = p[2*W-1:W];
    l = p[W-1:0];
  endfunction

  function automatic void ref_div(input bit s, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    longint nx, ny, lq, lr;
    if (s) begin
      nx = longint'($signed(x));
      ny = longint'($signed(y));
    end else begin
      nx = longint'({32'b0, x});
      ny = longint'({32'b0, y});
    end
    lq = nx / ny;
    lr = nx % ny;
    q = lq[W-1:0];
    r = lr[W-1:0];
  endfunction

  // monitor: every done pulse must match the oldest pending expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (!rst) begin
        if (done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
          end else begin
            e = sb.pop_front();
            chk("done_hi", hi_o, e.hi);
            chk("done_lo", lo_o, e.lo);
            chk("done_div_zero", 32'(div_zero), 32'(e.dz));
          end
        end else if (div_zero) begin
          chk("div_zero_without_done", 32'(div_zero), 32'd0);
        end
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    start = 1'b0; op = 3'b000;
  endtask

  task automatic do_mt(input bit to_hi, input logic [W-1:0] d);
    if (to_hi) model_hi = d; else model_lo = d;
    issue(to_hi ? OP_MTHI : OP_MTLO, d, $urandom);
    chk("mt_hi", hi_o, model_hi);
    chk("mt_lo", lo_o, model_lo);
  endtask

  task automatic do_mul(input bit s, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] h, l;
    ref_mul(s, x, y, h, l);
    sb.push_back('{hi: h, lo: l, dz: 1'b0});
    model_hi = h; model_lo = l;
    issue(s ? OP_MULT : OP_MULTU, x, y);
    chk("mul_busy", 32'(busy), 32'd0);
  endtask

  // flush_cyc / mtlo_cyc < 0 disable the mid-divide flush / illegal MTLO injection
  task automatic do_div(input bit s, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int flush_cyc, input int mtlo_cyc);
    logic [W-1:0] q, r, old_hi, old_lo;
    int n;
    old_hi = model_hi; old_lo = model_lo;
    if (y == '0) begin
      sb.push_back('{hi: model_hi, lo: model_lo, dz: 1'b1});
      issue(s ? OP_DIV : OP_DIVU, x, y);
      chk("div0_busy", 32'(busy), 32'd0);
      return;
    end
    if (flush_cyc < 0) begin
      ref_div(s, x, y, q, r);
      sb.push_back('{hi: r, lo: q, dz: 1'b0});
      model_hi = r; model_lo = q;
    end
    issue(s ? OP_DIV : OP_DIVU, x, y);
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == mtlo_cyc) begin
        start = 1'b1; op = OP_MTLO; a = $urandom;
      end
      if (n == mtlo_cyc + 1) begin
        start = 1'b0; op = 3'b000;
        chk("mtlo_while_busy", lo_o, old_lo);
      end
      if (n == flush_cyc) flush = 1'b1;
      @(posedge clk);
      flush = 1'b0;
    end
    start = 1'b0;
    if (flush_cyc >= 0) begin
      chk("flush_busy_cycles", 32'(n), 32'(flush_cyc));
      chk("flush_hi", hi_o, old_hi);
      chk("flush_lo", lo_o, old_lo);
    end else begin
      chk("div_busy_cycles", 32'(n), 32'(W + 1));
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h0000_0001;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [W-1:0] x, y;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0;
    model_hi = '0; model_lo = '0;
    #3;
    chk("reset_hi", hi_o, '0);
    chk("reset_lo", lo_o, '0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    @(posedge clk);
    rst = 1'b0;
    @(posedge clk);

    do_mul(1'b1, 32'hFFFF_FFFE, 32'd3);
    chk("mult_hi_const", hi_o, 32'hFFFF_FFFF);
    do_mul(1'b0, 32'hFFFF_FFFE, 32'd3);
    chk("multu_hi_const", hi_o, 32'h0000_0002);
    chk("multu_lo_const", lo_o, 32'hFFFF_FFFA);

    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, -1, -1);
    do_div(1'b0, 32'd100, 32'd7, -1, -1);
    chk("divu_lo_const", lo_o, 32'd14);
    chk("divu_hi_const", hi_o, 32'd2);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    chk("divmin_lo_const", lo_o, 32'h8000_0000);
    do_div(1'b1, 32'd5, 32'd0, -1, -1);
    @(posedge clk);

    do_div(1'b0, 32'd100, 32'd7, 10, -1);
    @(posedge clk);
    do_mul(1'b1, 32'd12345, 32'hFFFF_0000);

    do_mt(1'b1, 32'h0000_1234);
    do_mt(1'b0, 32'h0000_5678);
    do_div(1'b0, 32'hDEAD_BEEF, 32'd13, -1, 5);

    // start and flush on the same edge must have no effect
    start = 1'b1; op = OP_MTHI; a = 32'hCAFE_F00D; flush = 1'b1;
    @(posedge clk);
    op = OP_DIV; b = 32'd3;
    @(posedge clk);
    start = 1'b0; flush = 1'b0; op = 3'b000;
    @(posedge clk);
    chk("start_flush_hi", hi_o, model_hi);
    chk("start_flush_lo", lo_o, model_lo);
    chk("start_flush_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 40; i++) begin
      x = pick();
      y = ($urandom_range(0, 9) == 0) ? '0 : pick();
      case ($urandom_range(0, 5))
        0: do_mul(1'b1, x, y);
        1: do_mul(1'b0, x, y);
        2: do_div(1'b1, x, y, -1, -1);
        3: do_div(1'b0, x, y, -1, -1);
        4: do_mt(1'b1, x);
        default: do_mt(1'b0, x);
      endcase
    end
    @(posedge clk);
    @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    // asynchronous reset mid-divide, checked before any further clock edge
    do_mt(1'b1, 32'h1111_2222);
    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_hi", hi_o, '0);
    chk("async_rst_lo", lo_o, '0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    @(posedge clk);
    rst = 1'b0;
    model_hi = '0; model_lo = '0;
    repeat (3) @(posedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
